// File: rtl/jk_bank_arbiter.sv
// Shared bank of WIDTH JK flip-flops driven by NREQ requesters through a
// round-robin arbiter with burst lock and a one-stage command pipeline.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_mask,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        q_,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_q
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   lock_id;
  logic             lock_vld;
  logic             lock_hit;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic             s1_vld;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_mask;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] q_next;

  // The lock holds only while the owner keeps both valid and lock asserted.
  assign lock_hit = lock_vld & req_valid[lock_id] & req_lock[lock_id];

  // Grant: lock owner first, otherwise first valid requester from ptr upward.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    if (!rst && en) begin
      if (lock_hit) begin
        grant[lock_id] = 1'b1;
        gnt_id         = lock_id;
      end else begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          idx = IDW'((32'(ptr) + k) % NREQ);
          if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gnt_id     = idx;
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;

  // Pick the granted requester's command fields.
  always_comb begin
    sel_op   = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_mask = req_mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // JK characteristic: q+ = j&~q | ~k&q, applied only where the mask is set.
  assign jk_next = ({WIDTH{s1_op[1]}} & ~q) | ({WIDTH{~s1_op[0]}} & q);
  assign q_next  = (s1_mask & jk_next) | (~s1_mask & q);
  assign q_      = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      s1_vld    <= 1'b0;
      s1_op     <= '0;
      s1_mask   <= '0;
      s1_id     <= '0;
      q         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
    end else begin
      if (accept) begin
        if (!lock_hit) ptr <= IDW'((32'(gnt_id) + 1) % NREQ);
        lock_vld <= req_lock[gnt_id];
        lock_id  <= gnt_id;
        s1_op    <= sel_op;
        s1_mask  <= sel_mask;
        s1_id    <= gnt_id;
      end else begin
        lock_vld <= 1'b0;
      end
      s1_vld    <= accept;
      rsp_valid <= s1_vld;
      if (s1_vld) begin
        q      <= q_next;
        rsp_id <= s1_id;
        rsp_q  <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NREQ=4, WIDTH=8) with hand-computed expectations.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_mask;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [7:0]  q;
  logic [7:0]  q_;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_q;

  int checks = 0;
  int errors = 0;
  logic pend_v = 1'b0;
  int   pend_id = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_op(req_op), .req_mask(req_mask), .req_lock(req_lock),
    .req_ready(req_ready), .q(q), .q_(q_),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [1:0] op, input logic [7:0] mask);
    req_op[2*i +: 2]   = op;
    req_mask[8*i +: 8] = mask;
  endtask

  // Check the grant before the edge, then the response of the previous acceptance after it.
  task automatic grant_step(input int exp_id, input int exp_rq);
    logic [3:0] exp_rdy;
    #1;
    exp_rdy = (exp_id < 0) ? 4'b0000 : 4'(1 << exp_id);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(pend_v));
    if (pend_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(pend_id));
      if (exp_rq >= 0) chk("rsp_q", 32'(rsp_q), 32'(exp_rq));
    end
    pend_v  = (exp_id >= 0);
    pend_id = exp_id;
  endtask

  initial begin
    // Reset with every requester valid: no grant may be issued.
    rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_lock = 4'h0;
    req_op = 8'h00; req_mask = 32'hFFFF_FFFF;
    #1;
    chk("ready_in_rst", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qn", 32'(q_), 32'hFF);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_q", 32'(rsp_q), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);

    // Single set on req0.
    rst = 1'b0; req_valid = 4'b0001; set_cmd(0, 2'b10, 8'h0F);
    grant_step(0, -1);
    req_valid = 4'b0000;
    grant_step(-1, 8'h0F);
    chk("set_q", 32'(q), 32'h0F);
    chk("set_qn", 32'(q_), 32'hF0);

    // Fresh reset, then pure round-robin with no-op commands.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; pend_v = 1'b0;
    req_valid = 4'hF; req_op = 8'h00; req_mask = 32'hFFFF_FFFF;
    grant_step(0, 0); grant_step(1, 0); grant_step(2, 0);
    grant_step(3, 0); grant_step(0, 0); grant_step(1, 0);

    // Lock burst by req2, then release.
    req_lock = 4'b0100;
    grant_step(2, 0); grant_step(2, 0); grant_step(2, 0);
    req_lock = 4'b0000;
    grant_step(3, 0); grant_step(0, 0); grant_step(1, 0);

    // Set 0x0F, then toggle twice back-to-back.
    req_valid = 4'b0001; set_cmd(0, 2'b10, 8'h0F);
    grant_step(0, 0);
    req_valid = 4'b0010; set_cmd(1, 2'b11, 8'hFF);
    grant_step(1, 8'h0F);
    grant_step(1, 8'hF0);
    req_valid = 4'b0000;
    grant_step(-1, 8'h0F);
    chk("toggle_q", 32'(q), 32'h0F);

    // Reset lands while req3's command sits in stage 1.
    req_valid = 4'b1000; set_cmd(3, 2'b10, 8'h80);
    grant_step(3, -1);
    rst = 1'b1; req_valid = 4'b0000;
    #1;
    chk("inflight_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("inflight_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("inflight_q", 32'(q), 32'h00);
    chk("inflight_qn", 32'(q_), 32'hFF);
    rst = 1'b0; pend_v = 1'b0;
    #1;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

    // Enable low: nothing accepted, q holds.
    req_valid = 4'b0001; set_cmd(0, 2'b10, 8'h3C);
    grant_step(0, -1);
    req_valid = 4'b0000;
    grant_step(-1, 8'h3C);
    en = 1'b0; req_valid = 4'hF; req_op = 8'hFF; req_mask = 32'hFFFF_FFFF;
    grant_step(-1, -1); grant_step(-1, -1);
    chk("en_low_q", 32'(q), 32'h3C);

    // Command accepted just before en drops still completes.
    en = 1'b1; req_valid = 4'b0010; set_cmd(1, 2'b10, 8'h01);
    grant_step(1, -1);
    en = 1'b0; req_valid = 4'hF;
    grant_step(-1, 8'h3D);
    grant_step(-1, -1);
    chk("en_drain_q", 32'(q), 32'h3D);
    chk("en_drain_qn", 32'(q_), 32'hC2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
